// File: rtl/nmr_acq_gate_pkg.sv
// nmr_acq_gate_pkg: shared state encoding and microsecond divider defaults for the NMR pulse chain.
package nmr_acq_gate_pkg;
    localparam int US_DIVIDER = 125;
    localparam int US_DIVIDER_WIDTH = 8;
    typedef enum logic [1:0] {IDLE = 2'd0, TX = 2'd1, DEAD = 2'd2, ACQ = 2'd3} state_t;
endpackage

// File: rtl/us_tick_gen.sv
// us_tick_gen: free-running down counter producing a one-cycle tick every DIV clocks.
module us_tick_gen #(
    parameter int DIV = 125,
    parameter int W = 8
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    logic [W-1:0] cnt;
    assign tick = cnt == '0;
    always_ff @(posedge clk) begin
        if (rst) cnt <= W'(DIV - 1);
        else cnt <= tick ? W'(DIV - 1) : cnt - W'(1);
    end
endmodule

// File: rtl/nmr_acq_gate.sv
// nmr_acq_gate: receiver blanking, dead-time delay and box-car decimated acquisition windows on a stream.
module nmr_acq_gate #(
    parameter int US_DIVIDER = nmr_acq_gate_pkg::US_DIVIDER,
    parameter int US_DIVIDER_WIDTH = nmr_acq_gate_pkg::US_DIVIDER_WIDTH,
    parameter int ADC_WIDTH = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_seq,
    input  logic                 pulse_on,
    input  logic [ADC_WIDTH-1:0] adc_dat,
    input  logic [15:0]          dead_time,
    input  logic [15:0]          dec,
    input  logic [31:0]          acq_len,
    output logic                 rx_blank,
    output logic [31:0]          m_tdata,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic                 m_tlast,
    output logic                 ovf,
    output logic                 abort
);
    import nmr_acq_gate_pkg::*;
    state_t state;
    logic tick, start_d, armed, blank_r, rise, arm_now, emit, last;
    logic [15:0] dcnt, dcount, dec_eff;
    logic [31:0] acc, scnt, sum, adc_x;
    us_tick_gen #(.DIV(US_DIVIDER), .W(US_DIVIDER_WIDTH)) u_tick (.clk(clk), .rst(rst), .tick(tick));
    assign adc_x = {{(32 - ADC_WIDTH){adc_dat[ADC_WIDTH-1]}}, adc_dat};
    assign sum = acc + adc_x;
    assign dec_eff = dec == '0 ? 16'd1 : dec;
    assign emit = dcount >= dec_eff - 16'd1;
    assign last = emit && scnt == acq_len - 32'd1;
    assign rise = start_seq && !start_d;
    assign arm_now = armed || rise;
    assign rx_blank = pulse_on || blank_r;
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            armed    <= 1'b0;
            start_d  <= 1'b0;
            blank_r  <= 1'b1;
            dcnt     <= '0;
            dcount   <= '0;
            acc      <= '0;
            scnt     <= '0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            m_tdata  <= '0;
            ovf      <= 1'b0;
            abort    <= 1'b0;
        end else begin
            start_d <= start_seq;
            armed   <= arm_now;
            if (rise) begin
                ovf   <= 1'b0;
                abort <= 1'b0;
            end
            if (m_tready) begin
                m_tvalid <= 1'b0;
                m_tlast  <= 1'b0;
            end
            case (state)
                IDLE: begin
                    blank_r <= arm_now && pulse_on;
                    if (arm_now && pulse_on) state <= TX;
                end
                TX: if (!pulse_on) begin
                    state <= DEAD;
                    dcnt  <= dead_time;
                end
                DEAD: if (pulse_on) state <= TX;
                else if (dcnt == '0) begin
                    state   <= acq_len == '0 ? IDLE : ACQ;
                    blank_r <= 1'b0;
                    acc     <= '0;
                    dcount  <= '0;
                    scnt    <= '0;
                end else if (tick) dcnt <= dcnt - 16'd1;
                ACQ: if (pulse_on && !last) begin
                    state   <= TX;
                    blank_r <= 1'b1;
                    abort   <= 1'b1;
                end else begin
                    acc    <= emit ? '0 : sum;
                    dcount <= emit ? '0 : dcount + 16'd1;
                    if (emit) begin
                        scnt <= scnt + 32'd1;
                        if (!m_tvalid || m_tready) begin
                            m_tvalid <= 1'b1;
                            m_tdata  <= sum;
                            m_tlast  <= last;
                        end else ovf <= 1'b1;
                    end
                    // A final sample coinciding with a new pulse still completes the window.
                    if (last) begin
                        state   <= pulse_on ? TX : IDLE;
                        blank_r <= pulse_on;
                    end
                end
            endcase
        end
    end
endmodule
